// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: streams operands through a single MAC,
// adds the bias and emits one saturated result per neuron on a valid/ready port.
module fc_seq_ctrl #(
    parameter int N_IN  = 9,
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int ACCW  = 24,
    parameter int OW    = 16,
    localparam int IAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WAW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int NAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    output logic [IAW-1:0] o_in_addr,
    input  logic [DW-1:0]  i_in_data,
    output logic [WAW-1:0] o_w_addr,
    input  logic [DW-1:0]  i_w_data,
    output logic [NAW-1:0] o_b_addr,
    input  logic [DW-1:0]  i_b_data,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [OW-1:0]  o_out_data,
    output logic [NAW-1:0] o_out_idx
);

    localparam int KW = $clog2(N_IN + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_BIAS = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [2:0]             r_state;
    logic [NAW-1:0]         r_n;
    logic [KW-1:0]          r_k;
    logic signed [ACCW-1:0] r_acc;
    logic [IAW-1:0]         r_in_addr;
    logic [WAW-1:0]         r_w_addr;
    logic                   r_out_valid;
    logic [OW-1:0]          r_out_data;

    logic signed [2*DW-1:0] w_a;
    logic signed [2*DW-1:0] w_b;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_sum;
    logic [OW-1:0]          w_sat;

    always_comb begin
        w_a    = (2*DW)'($signed(i_in_data));
        w_b    = (2*DW)'($signed(i_w_data));
        w_prod = w_a * w_b;
        w_sum  = r_acc + ACCW'($signed(i_b_data));
        w_sat  = w_sum[OW-1:0];
        if (w_sum > SAT_MAX) begin
            w_sat = SAT_MAX[OW-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_sat = SAT_MIN[OW-1:0];
        end
    end

    // r_k counts MAC cycles 0..N_IN; data for address k arrives at cycle k+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_in_addr   <= '0;
            r_w_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_MAC;
                        r_n       <= '0;
                        r_k       <= '0;
                        r_acc     <= '0;
                        r_in_addr <= '0;
                        r_w_addr  <= '0;
                    end
                end
                S_MAC: begin
                    if (r_k != '0) begin
                        r_acc <= r_acc + ACCW'(w_prod);
                    end
                    if (r_k == KW'(N_IN)) begin
                        r_state <= S_BIAS;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                    if (r_k < KW'(N_IN - 1)) begin
                        r_in_addr <= r_in_addr + IAW'(1);
                        r_w_addr  <= r_w_addr + WAW'(1);
                    end
                end
                S_BIAS: begin
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_n == NAW'(N_OUT - 1)) begin
                            r_state <= S_FIN;
                        end else begin
                            // w_addr rests on the row's last word, so +1 starts the next row
                            r_state   <= S_MAC;
                            r_n       <= r_n + NAW'(1);
                            r_k       <= '0;
                            r_acc     <= '0;
                            r_in_addr <= '0;
                            r_w_addr  <= r_w_addr + WAW'(1);
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done      = (r_state == S_FIN);
    assign o_in_addr   = r_in_addr;
    assign o_w_addr    = r_w_addr;
    assign o_b_addr    = r_n;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_n;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Randomized bench for fc_seq_ctrl: synchronous memory models plus a
// cycle-level reference built from the layer's dot-product and timing rules.
module tb_fc_seq_ctrl;

    localparam int N_IN  = 9;
    localparam int N_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_in_addr;
    logic [7:0]  i_in_data;
    logic [5:0]  o_w_addr;
    logic [7:0]  i_w_data;
    logic [1:0]  o_b_addr;
    logic [7:0]  i_b_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [15:0] o_out_data;
    logic [1:0]  o_out_idx;

    logic signed [7:0] in_mem [0:15];
    logic signed [7:0] w_mem  [0:63];
    logic signed [7:0] b_mem  [0:3];

    int n_checks = 0;
    int n_pass   = 0;

    fc_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_in_addr   (o_in_addr),
        .i_in_data   (i_in_data),
        .o_w_addr    (o_w_addr),
        .i_w_data    (i_w_data),
        .o_b_addr    (o_b_addr),
        .i_b_data    (i_b_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_idx   (o_out_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_in_data <= in_mem[o_in_addr];
        i_w_data  <= w_mem[o_w_addr];
        i_b_data  <= b_mem[o_b_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected neuron result: plain dot product + bias, clamped to 16 bits.
    function automatic logic [15:0] ref_out(input int n);
        int s;
        s = int'(b_mem[n]);
        for (int k = 0; k < N_IN; k++) begin
            s += int'(in_mem[k]) * int'(w_mem[n*N_IN + k]);
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic fill(input int pat);
        for (int k = 0; k < N_IN; k++) begin
            case (pat)
                0: in_mem[k] = 8'sd1;
                1: in_mem[k] = 8'sd127;
                2: in_mem[k] = -8'sd128;
                3: in_mem[k] = 8'(k - 4);
                default: in_mem[k] = 8'($urandom);
            endcase
        end
        for (int i = 0; i < N_IN*N_OUT; i++) begin
            case (pat)
                0: w_mem[i] = 8'sd2;
                1, 2: w_mem[i] = 8'sd127;
                3: w_mem[i] = 8'sd1;
                default: w_mem[i] = 8'($urandom);
            endcase
        end
        for (int n = 0; n < N_OUT; n++) begin
            case (pat)
                0: b_mem[n] = 8'sd3;
                1: b_mem[n] = 8'sd127;
                2: b_mem[n] = -8'sd128;
                3: b_mem[n] = 8'sd0;
                default: b_mem[n] = 8'($urandom);
            endcase
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq(tag, 32'({o_busy, o_done, o_out_valid, o_out_data, o_out_idx,
                           o_in_addr, o_w_addr, o_b_addr}), 32'd0);
    endtask

    // mode 0: ready high, 1: random ready and start pulses, 2: ready low 5 cycles
    // on neuron 1, 3: reset during neuron 2 MAC. exp_done < 0 skips the done-cycle check.
    task automatic run_layer(input int mode, input bit hold_start, input int exp_done);
        int  cyc;
        int  next_valid;
        int  nidx;
        int  last_hs;
        int  s;
        bit  exp_valid;
        bit  fin;
        @(negedge clk);
        i_start     = 1'b1;
        i_out_ready = 1'b1;
        cyc         = 0;
        next_valid  = 12;
        nidx        = 0;
        last_hs     = -100;
        fin         = 1'b0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) i_start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                1: i_out_ready = ($urandom_range(0, 3) != 0);
                2: i_out_ready = !(nidx == 1 && cyc >= next_valid && cyc < next_valid + 5);
                default: i_out_ready = 1'b1;
            endcase
            if (mode == 3 && cyc == 28) begin
                rst = 1'b1;
                @(negedge clk);
                check_idle("abort_reset");
                rst     = 1'b0;
                i_start = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check_eq("abort_quiet", 32'({o_done, o_busy, o_out_valid}), 32'd0);
                end
                return;
            end
            exp_valid = (nidx < N_OUT) && (cyc >= next_valid);
            fin       = (nidx == N_OUT) && (cyc == last_hs + 1);
            check_eq("valid", 32'(o_out_valid), 32'(exp_valid));
            check_eq("busy", 32'(o_busy), 32'(!fin));
            check_eq("done", 32'(o_done), 32'(fin));
            if (exp_valid) begin
                check_eq("out_data", 32'(o_out_data), 32'(ref_out(nidx)));
                check_eq("out_idx", 32'(o_out_idx), 32'(nidx));
            end
            s = next_valid - 11;
            if (nidx < N_OUT && cyc >= s && cyc < s + N_IN) begin
                check_eq("addr", 32'({o_in_addr, o_w_addr, o_b_addr}),
                         32'({4'(cyc - s), 6'(nidx*N_IN + cyc - s), 2'(nidx)}));
            end
            if (exp_valid && i_out_ready) begin
                nidx++;
                next_valid = cyc + 12;
                last_hs    = cyc;
            end
        end
        if (!fin) check_eq("timeout", 32'(cyc), 32'(0));
        if (exp_done >= 0) check_eq("done_cycle", 32'(cyc), 32'(exp_done));
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        fill(0);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        fill(0); run_layer(0, 1'b0, 49);
        fill(1); run_layer(0, 1'b0, 49);
        fill(2); run_layer(0, 1'b0, 49);
        fill(3); run_layer(0, 1'b0, 49);
        fill(4); run_layer(2, 1'b0, 54);
        fill(4); run_layer(3, 1'b0, -1);
        run_layer(0, 1'b0, 49);

        // start held high: ignored in FIN, accepted from the following cycle
        fill(0); run_layer(0, 1'b1, 49);
        @(negedge clk);
        check_eq("hold_idle", 32'(o_busy), 32'd0);
        @(negedge clk);
        check_eq("hold_restart", 32'(o_busy), 32'd1);
        i_start = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 4; r++) begin
            fill(4);
            run_layer(1, 1'b0, -1);
        end
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
